// File: rtl/button_event.sv
// rtl/button_event.sv - press/release/hold/repeat event generator for a debounced switch
//
// Purpose: turns a debounced, clock-synchronous switch level into one-cycle
// event pulses (press, release, hold, repeat) plus a held level and a
// saturating repeat count. All outputs are registered.
//
// Optional feature macro: BUTTON_EVENT_REPEAT_EN
//   defined   -> repeat pulses and repeat count are active while held
//   undefined -> o_Repeat and o_Repeat_Count stay 0, HOLD counter is frozen
//
// Ports:
//   i_Clk          in   1  clock, rising edge
//   i_Rst          in   1  asynchronous active-high reset
//   i_Switch       in   1  debounced switch level, 1 = pressed
//   o_Press        out  1  one-cycle pulse on press
//   o_Release      out  1  one-cycle pulse on release
//   o_Hold         out  1  one-cycle pulse when the press reaches c_HOLD_LIMIT
//   o_Repeat       out  1  one-cycle pulse per repeat interval while held
//   o_Held         out  1  high while in HOLD
//   o_Repeat_Count out  8  repeats in the current hold, saturating at 255

module button_event #(
  parameter int c_HOLD_LIMIT   = 12500000,
  parameter int c_REPEAT_LIMIT = 2500000
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Switch,
  output logic       o_Press,
  output logic       o_Release,
  output logic       o_Hold,
  output logic       o_Repeat,
  output logic       o_Held,
  output logic [7:0] o_Repeat_Count
);

  localparam int CNT_MAX = (c_HOLD_LIMIT > c_REPEAT_LIMIT) ? c_HOLD_LIMIT : c_REPEAT_LIMIT;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(c_HOLD_LIMIT - 1);
`ifdef BUTTON_EVENT_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(c_REPEAT_LIMIT - 1);
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             hold_q, hold_d;
  logic             repeat_q, repeat_d;
  logic             held_q, held_d;
  logic [7:0]       rcount_q, rcount_d;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      hold_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
      rcount_q  <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      hold_q    <= hold_d;
      repeat_q  <= repeat_d;
      held_q    <= held_d;
      rcount_q  <= rcount_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    hold_d    = 1'b0;
    repeat_d  = 1'b0;
    rcount_d  = rcount_q;

    case (state_q)
      IDLE: begin
        cnt_d    = '0;
        rcount_d = 8'd0;
        if (i_Switch) begin
          press_d = 1'b1;
          state_d = PRESS;
        end
      end

      PRESS: begin
        // Release is checked first so it wins over a hold on the same edge.
        if (!i_Switch) begin
          release_d = 1'b1;
          state_d   = IDLE;
          cnt_d     = '0;
          rcount_d  = 8'd0;
        end else if (cnt_q == HOLD_LAST) begin
          hold_d  = 1'b1;
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      HOLD: begin
        if (!i_Switch) begin
          release_d = 1'b1;
          state_d   = IDLE;
          cnt_d     = '0;
          rcount_d  = 8'd0;
        end else begin
`ifdef BUTTON_EVENT_REPEAT_EN
          if (cnt_q == REPEAT_LAST) begin
            repeat_d = 1'b1;
            cnt_d    = '0;
            if (rcount_q != 8'hFF) begin
              rcount_d = rcount_q + 8'd1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
`else
          // Without repeats the counter has nothing to time in HOLD.
          cnt_d    = cnt_q;
          rcount_d = 8'd0;
`endif
        end
      end

      default: begin
        state_d  = IDLE;
        cnt_d    = '0;
        rcount_d = 8'd0;
      end
    endcase
  end

  // Held is registered from the next state so it rises with o_Hold and
  // falls with o_Release.
  assign held_d = (state_d == HOLD);

  assign o_Press        = press_q;
  assign o_Release      = release_q;
  assign o_Hold         = hold_q;
  assign o_Repeat       = repeat_q;
  assign o_Held         = held_q;
  assign o_Repeat_Count = rcount_q;

endmodule

// File: tb/tb_button_event.sv
// tb/tb_button_event.sv - self-checking bench for button_event

module tb_button_event;

  localparam int H = 10;
  localparam int R = 4;
`ifdef BUTTON_EVENT_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic       clk;
  logic       i_Rst;
  logic       i_Switch;
  logic       o_Press, o_Release, o_Hold, o_Repeat, o_Held;
  logic [7:0] o_Repeat_Count;

  button_event #(.c_HOLD_LIMIT(H), .c_REPEAT_LIMIT(R)) dut (
    .i_Clk          (clk),
    .i_Rst          (i_Rst),
    .i_Switch       (i_Switch),
    .o_Press        (o_Press),
    .o_Release      (o_Release),
    .o_Hold         (o_Hold),
    .o_Repeat       (o_Repeat),
    .o_Held         (o_Held),
    .o_Repeat_Count (o_Repeat_Count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {press, release, hold, repeat, held, count[7:0]}
  wire [12:0] outs = {o_Press, o_Release, o_Hold, o_Repeat, o_Held, o_Repeat_Count};

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (p r h rp held cnt)", name, act, exp);
    end
  endtask

  function automatic logic [12:0] pk(input bit p, input bit r, input bit h,
                                     input bit rp, input bit hd, input int cnt);
    return {p, r, h, rp, hd, 8'(cnt)};
  endfunction

  // Reference model: counts edges since the press edge and derives events
  // from that elapsed count.
  bit         m_pressed = 1'b0;
  int         m_n = 0;
  int         m_cnt = 0;
  logic [12:0] m_out = '0;

  task automatic model_step(input bit sw);
    bit p, r, h, rp;
    p = 0; r = 0; h = 0; rp = 0;
    if (!m_pressed) begin
      if (sw) begin
        p = 1; m_pressed = 1; m_n = 0;
      end
    end else if (!sw) begin
      r = 1; m_pressed = 0; m_n = 0; m_cnt = 0;
    end else begin
      m_n++;
      if (m_n == H) h = 1;
      if (REP_EN && m_n > H && ((m_n - H) % R) == 0) begin
        rp = 1;
        if (m_cnt < 255) m_cnt++;
      end
    end
    m_out = pk(p, r, h, rp, m_pressed && (m_n >= H), m_cnt);
  endtask

  task automatic model_reset();
    m_pressed = 0; m_n = 0; m_cnt = 0; m_out = '0;
  endtask

  // One clock: drive, let the edge happen, compare against the model.
  task automatic tick(input bit sw);
    i_Switch = sw;
    @(posedge clk);
    model_step(sw);
    #1;
    check("model", outs, m_out);
    checks++;
    if ($countones({o_Press, o_Release, o_Hold, o_Repeat}) > 1) begin
      errors++;
      $display("FAIL onehot actual=%b required=at most one pulse",
               {o_Press, o_Release, o_Hold, o_Repeat});
    end
  endtask

  // Asynchronous reset applied between edges, outputs must clear at once.
  task automatic do_reset();
    #2;
    i_Rst = 1'b1;
    #1;
    model_reset();
    check("rst_async", outs, 13'd0);
    @(posedge clk);
    #1;
    check("rst_hold", outs, 13'd0);
    i_Rst = 1'b0;
  endtask

  typedef struct {
    bit          sw;
    logic [12:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit sw, input logic [12:0] exp);
    vec_t v;
    v.sw = sw; v.exp = exp;
    vecs.push_back(v);
  endtask

  initial begin : main
    int hold_edge;
    int rep_seen;
    int len;

    i_Rst    = 1'b1;
    i_Switch = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", outs, 13'd0);
    i_Rst = 1'b0;

    // 5-cycle press then release
    add(1, pk(1,0,0,0,0,0));
    for (int i = 0; i < 4; i++) add(1, pk(0,0,0,0,0,0));
    add(0, pk(0,1,0,0,0,0));
    add(0, pk(0,0,0,0,0,0));
    // 1-cycle press
    add(1, pk(1,0,0,0,0,0));
    add(0, pk(0,1,0,0,0,0));
    add(0, pk(0,0,0,0,0,0));
    // release exactly at edge 10: no hold
    add(1, pk(1,0,0,0,0,0));
    for (int i = 0; i < 9; i++) add(1, pk(0,0,0,0,0,0));
    add(0, pk(0,1,0,0,0,0));
    add(0, pk(0,0,0,0,0,0));
    // press held through edge 10: hold fires, then release
    add(1, pk(1,0,0,0,0,0));
    for (int i = 0; i < 9; i++) add(1, pk(0,0,0,0,0,0));
    add(1, pk(0,0,1,0,1,0));
    add(0, pk(0,1,0,0,0,0));

    for (int i = 0; i < vecs.size(); i++) begin
      i_Switch = vecs[i].sw;
      @(posedge clk);
      model_step(vecs[i].sw);
      #1;
      check($sformatf("vec%0d", i), outs, vecs[i].exp);
    end

    // 23 high cycles: hold at edge 10, repeats at 14/18/22
    hold_edge = -1;
    rep_seen  = 0;
    for (int e = 0; e < 23; e++) begin
      tick(1);
      if (o_Hold) hold_edge = e;
      if (o_Repeat) rep_seen++;
    end
    check("hold_edge", 13'(hold_edge), 13'd10);
    check("rep_pulses", 13'(rep_seen), REP_EN ? 13'd3 : 13'd0);
    check("rep_count23", {5'd0, o_Repeat_Count}, REP_EN ? 13'd3 : 13'd0);
    check("held23", {12'd0, o_Held}, 13'd1);
    tick(0);
    check("release23", {12'd0, o_Release}, 13'd1);
    tick(0);

    // long hold: saturation while repeats keep coming
    rep_seen = 0;
    for (int e = 0; e < 1100; e++) begin
      tick(1);
      if (o_Repeat) rep_seen++;
    end
    check("sat_count", {5'd0, o_Repeat_Count}, REP_EN ? 13'd255 : 13'd0);
    check("sat_pulses", 13'(rep_seen), REP_EN ? 13'(((1099 - H) / R)) : 13'd0);
    tick(0);
    tick(0);

    // reset mid-hold with switch still pressed
    for (int e = 0; e < 16; e++) tick(1);
    do_reset();
    tick(1);
    check("press_after_rst", {12'd0, o_Press}, 13'd1);
    tick(0);
    tick(0);

    // randomized bursts with occasional reset
    for (int b = 0; b < 60; b++) begin
      len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++) tick(1);
      if ($urandom_range(0, 9) == 0) do_reset();
      len = $urandom_range(1, 5);
      for (int i = 0; i < len; i++) tick(0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
